// File: rtl/axi_fwd_pkg.sv
// Shared definitions for the AXI-stream forwarding lookup stage.
//   fwd_state_e     : forwarding FSM state encoding (IDLE=0, LOOKUP=1, REQ=2, WAIT_EOP=3)
//   port_width()    : width of the port field of a table entry
//   entry_valid_bit : bit index of the valid flag within a table entry {valid, port}
package axi_fwd_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLookup  = 2'd1,
        StReq     = 2'd2,
        StWaitEop = 2'd3
    } fwd_state_e;

    function automatic int unsigned port_width(input int unsigned num_outputs);
        return (num_outputs > 1) ? $clog2(num_outputs) : 1;
    endfunction

    // Entry layout is {valid, port}: valid sits just above the port field.
    function automatic int unsigned entry_valid_bit(input int unsigned num_outputs);
        return port_width(num_outputs);
    endfunction

endpackage

// File: rtl/axi_fwd_table.sv
// Host-programmable routing table held in flops, one write port and one registered read port.
//   clk, reset          : clock, asynchronous active-high reset (all entries cleared = invalid)
//   wr_en_i/addr/data   : write strobe, index and entry, applied on the clock edge
//   rd_en_i, rd_addr_i  : read request; entry is captured into rd_data_o on the clock edge
//   rd_data_o           : registered read data (holds until the next read)
// A read and a write of the same index on the same edge returns the old entry.
module axi_fwd_table #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned ENTRY_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [ENTRY_WIDTH-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [ENTRY_WIDTH-1:0] rd_data_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [ENTRY_WIDTH-1:0] mem_q [Depth];
    logic [ENTRY_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_forwarding_lut.sv
// Per-input forwarding decision stage for the AXI-stream crossbar.
// Watches one input stream, looks up the header's destination in the routing table, raises a
// one-hot forward request to the chosen slave mux and follows the packet to its last beat.
// It never drives tready and never moves data.
//   clk, reset       : clock, asynchronous active-high reset
//   clear            : synchronous FSM flush (table contents kept)
//   set_stb/addr/data: routing table write port, set_data = {entry_valid, port}
//   i_t*             : observed stream handshake/data
//   forward_valid    : one-hot request to the slave muxes
//   forward_ack      : acknowledges from the slave muxes
//   busy             : high whenever the FSM is not idle
module axi_forwarding_lut
    import axi_fwd_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH     = 64,
    parameter int unsigned DST_WIDTH      = 16,
    parameter int unsigned NUM_OUTPUTS    = 2,
    parameter int unsigned LUT_ADDR_WIDTH = 8,
    parameter int unsigned DEFAULT_PORT   = 0,
    localparam int unsigned PORT_W        = port_width(NUM_OUTPUTS),
    localparam int unsigned VALID_BIT     = entry_valid_bit(NUM_OUTPUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      set_stb,
    input  logic [LUT_ADDR_WIDTH-1:0] set_addr,
    input  logic [PORT_W:0]           set_data,
    input  logic [FIFO_WIDTH-1:0]     i_tdata,
    input  logic                      i_tvalid,
    input  logic                      i_tlast,
    input  logic                      i_tready,
    output logic [NUM_OUTPUTS-1:0]    forward_valid,
    input  logic [NUM_OUTPUTS-1:0]    forward_ack,
    output logic                      busy
);

    fwd_state_e                state_q, state_d;
    logic [LUT_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [DST_WIDTH-1:0]      hdr_dst;
    logic [PORT_W:0]           rd_entry;
    logic [PORT_W-1:0]         entry_port;
    logic                      entry_hit;
    logic [PORT_W-1:0]         req_port;
    logic                      ack_hit;
    logic                      xfer_last;
    logic                      unused_bits;

    assign hdr_dst     = i_tdata[DST_WIDTH-1:0];
    assign unused_bits = ^{i_tdata[FIFO_WIDTH-1:DST_WIDTH], hdr_dst[DST_WIDTH-1:LUT_ADDR_WIDTH]};

    // The registered read captured on the LOOKUP edge acts as the port register: it holds the
    // entry for the whole REQ/WAIT_EOP span because no other read is issued meanwhile.
    axi_fwd_table #(
        .ADDR_WIDTH  (LUT_ADDR_WIDTH),
        .ENTRY_WIDTH (PORT_W + 1)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (set_stb),
        .wr_addr_i (set_addr),
        .wr_data_i (set_data),
        .rd_en_i   (state_q == StLookup),
        .rd_addr_i (dst_q),
        .rd_data_o (rd_entry)
    );

    // Valid entries pointing past the last output fall back to the default port.
    assign entry_port = rd_entry[PORT_W-1:0];
    assign entry_hit  = rd_entry[VALID_BIT] && (32'(entry_port) < NUM_OUTPUTS);
    assign req_port   = entry_hit ? entry_port : PORT_W'(DEFAULT_PORT);

    assign ack_hit   = forward_ack[req_port];
    assign xfer_last = i_tvalid & i_tready & i_tlast;

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        unique case (state_q)
            StIdle: begin
                if (i_tvalid) begin
                    dst_d   = hdr_dst[LUT_ADDR_WIDTH-1:0];
                    state_d = StLookup;
                end
            end
            StLookup: state_d = StReq;
            StReq: begin
                // Transfers before the ack are a protocol error and are ignored here.
                if (ack_hit) begin
                    state_d = xfer_last ? StIdle : StWaitEop;
                end
            end
            StWaitEop: begin
                if (xfer_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
        end
    end

    // Decoded straight from flops, so glitch-free and high only while in REQ.
    assign forward_valid = (state_q == StReq) ? (NUM_OUTPUTS'(1) << req_port) : '0;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_axi_forwarding_lut.sv
module tb_axi_forwarding_lut;

    localparam int unsigned NOUT = 2;
    localparam int unsigned DEFP = 0;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [1:0]  set_data;
    logic [63:0] i_tdata;
    logic        i_tvalid;
    logic        i_tlast;
    logic        i_tready;
    logic [1:0]  forward_valid;
    logic [1:0]  forward_ack;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference routing table: plain arrays updated whenever the bench writes the DUT table.
    logic       lut_v [256];
    int         lut_p [256];

    axi_forwarding_lut dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .i_tdata       (i_tdata),
        .i_tvalid      (i_tvalid),
        .i_tlast       (i_tlast),
        .i_tready      (i_tready),
        .forward_valid (forward_valid),
        .forward_ack   (forward_ack),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] model_fv(input logic [15:0] dst);
        int a;
        int p;
        a = int'(dst[7:0]);
        p = (lut_v[a] && lut_p[a] < int'(NOUT)) ? lut_p[a] : int'(DEFP);
        return 2'(1 << p);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            lut_v[i] = 1'b0;
            lut_p[i] = 0;
        end
    endtask

    task automatic write_entry(input logic [7:0] a, input logic v, input logic p);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = {v, p};
        step();
        set_stb  = 1'b0;
        lut_v[a] = v;
        lut_p[a] = int'(p);
    endtask

    // Full packet: header, bounded wait for the request, ack after ack_dly cycles (with stray
    // acks on the other bit), then the remaining beats.
    task automatic send_pkt(input logic [15:0] dst, input int nbeats, input int ack_dly,
                            input logic [1:0] exp_fv, input string nm);
        int cyc;
        i_tdata        = {$urandom, $urandom};
        i_tdata[15:0]  = dst;
        i_tvalid       = 1'b1;
        i_tlast        = 1'b0;
        i_tready       = 1'b0;
        step();
        check({nm, ".lookup_busy"}, 64'(busy), 64'(1));
        check({nm, ".lookup_fv"}, 64'(forward_valid), 64'(0));
        cyc = 1;
        while (forward_valid == 2'b00 && cyc < 8) begin
            step();
            cyc++;
        end
        check({nm, ".latency"}, 64'(cyc), 64'(2));
        check({nm, ".fv"}, 64'(forward_valid), 64'(exp_fv));
        for (int k = 0; k < ack_dly; k++) begin
            forward_ack = (k % 2 == 1) ? ~exp_fv : 2'b00;
            step();
            check({nm, ".hold_fv"}, 64'(forward_valid), 64'(exp_fv));
        end
        forward_ack = exp_fv;
        i_tready    = 1'b1;
        i_tlast     = (nbeats == 1);
        step();
        forward_ack = 2'b00;
        check({nm, ".drop_fv"}, 64'(forward_valid), 64'(0));
        check({nm, ".ack_busy"}, 64'(busy), 64'(nbeats > 1));
        for (int b = 2; b <= nbeats; b++) begin
            i_tdata = {$urandom, $urandom};
            i_tlast = (b == nbeats);
            step();
        end
        i_tvalid = 1'b0;
        i_tready = 1'b0;
        i_tlast  = 1'b0;
        check({nm, ".eop_busy"}, 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [15:0] dst;
        logic        wr;
        logic        wr_v;
        logic        wr_p;
        int          nbeats;
        logic [1:0]  exp_fv;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{dst: 16'h0012, wr: 1'b1, wr_v: 1'b1, wr_p: 1'b1, nbeats: 4, exp_fv: 2'b10};
        vecs[1] = '{dst: 16'h0033, wr: 1'b0, wr_v: 1'b0, wr_p: 1'b0, nbeats: 3, exp_fv: 2'b01};
        vecs[2] = '{dst: 16'h0012, wr: 1'b0, wr_v: 1'b0, wr_p: 1'b0, nbeats: 1, exp_fv: 2'b10};
        vecs[3] = '{dst: 16'hAB07, wr: 1'b1, wr_v: 1'b1, wr_p: 1'b0, nbeats: 2, exp_fv: 2'b01};
        vecs[4] = '{dst: 16'h0109, wr: 1'b1, wr_v: 1'b0, wr_p: 1'b1, nbeats: 2, exp_fv: 2'b01};
        vecs[5] = '{dst: 16'h1234, wr: 1'b1, wr_v: 1'b1, wr_p: 1'b1, nbeats: 1, exp_fv: 2'b10};
        vecs[6] = '{dst: 16'h5534, wr: 1'b0, wr_v: 1'b0, wr_p: 1'b0, nbeats: 2, exp_fv: 2'b10};

        reset       = 1'b1;
        clear       = 1'b0;
        set_stb     = 1'b0;
        set_addr    = '0;
        set_data    = '0;
        i_tdata     = '0;
        i_tvalid    = 1'b0;
        i_tlast     = 1'b0;
        i_tready    = 1'b0;
        forward_ack = 2'b00;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset.fv", 64'(forward_valid), 64'(0));
        check("reset.busy", 64'(busy), 64'(0));

        // Table-driven packets, including a miss on 0x0033 and upper DST bits ignored.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) write_entry(vecs[i].dst[7:0], vecs[i].wr_v, vecs[i].wr_p);
            send_pkt(vecs[i].dst, vecs[i].nbeats, 1, vecs[i].exp_fv, $sformatf("vec%0d", i));
        end

        // Single-beat packet immediately followed by the next header.
        send_pkt(16'h0012, 1, 0, 2'b10, "sb_first");
        send_pkt(16'h0033, 2, 0, 2'b01, "sb_next");

        // Write on the LOOKUP edge of a packet to the same index: old entry wins.
        write_entry(8'h05, 1'b1, 1'b0);
        i_tdata  = 64'h0000_0000_0000_0005;
        i_tvalid = 1'b1;
        step();
        set_stb  = 1'b1;
        set_addr = 8'h05;
        set_data = 2'b11;
        step();
        set_stb  = 1'b0;
        lut_v[5] = 1'b1;
        lut_p[5] = 1;
        check("race.fv_old", 64'(forward_valid), 64'(2'b01));
        forward_ack = 2'b01;
        i_tready    = 1'b1;
        i_tlast     = 1'b1;
        step();
        forward_ack = 2'b00;
        i_tvalid    = 1'b0;
        i_tready    = 1'b0;
        i_tlast     = 1'b0;
        check("race.busy", 64'(busy), 64'(0));
        send_pkt(16'h0005, 2, 0, 2'b10, "race_next");

        // Long ack delay with stray acks on the other bit.
        send_pkt(16'h0012, 3, 10, 2'b10, "stray");

        // Randomised packets against the reference table.
        for (int r = 0; r < 30; r++) begin
            logic [15:0] d;
            if ($urandom_range(1, 0) == 1) begin
                write_entry(8'($urandom_range(15, 0)), 1'($urandom), 1'($urandom));
            end
            d = {8'($urandom), 8'($urandom_range(15, 0))};
            send_pkt(d, int'($urandom_range(4, 1)), int'($urandom_range(3, 0)), model_fv(d),
                     $sformatf("rnd%0d", r));
        end

        // clear in WAIT_EOP: FSM flushed, table kept.
        i_tdata  = 64'h0000_0000_0000_0012;
        i_tvalid = 1'b1;
        step();
        step();
        check("clr.fv", 64'(forward_valid), 64'(2'b10));
        forward_ack = 2'b10;
        i_tready    = 1'b1;
        step();
        forward_ack = 2'b00;
        i_tready    = 1'b0;
        check("clr.wait_busy", 64'(busy), 64'(1));
        clear    = 1'b1;
        i_tvalid = 1'b0;
        step();
        clear = 1'b0;
        check("clr.busy", 64'(busy), 64'(0));
        check("clr.fv0", 64'(forward_valid), 64'(0));
        send_pkt(16'h0012, 2, 0, model_fv(16'h0012), "after_clear");

        // Asynchronous reset while in REQ: request withdrawn immediately, table wiped.
        i_tdata  = 64'h0000_0000_0000_0012;
        i_tvalid = 1'b1;
        step();
        step();
        check("rst.fv_before", 64'(forward_valid), 64'(2'b10));
        #2;
        reset = 1'b1;
        #1;
        check("rst.fv", 64'(forward_valid), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        #1;
        reset    = 1'b0;
        i_tvalid = 1'b0;
        model_reset();
        step();
        check("rst.idle", 64'(busy), 64'(0));
        send_pkt(16'h0012, 2, 0, 2'b01, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
